// File: rtl/fb_ddr3_burst_writer.sv
// Frame-buffer drain: pops BURST_LEN words from the FIFO into a local buffer,
// then writes them as one Avalon-MM burst, walking a circular frame region.
module fb_ddr3_burst_writer #(
   parameter int WIDTH       = 512,
   parameter int ADDR_WIDTH  = 26,
   parameter int BURST_LEN   = 4,
   parameter int FRAME_WORDS = 1024,
   parameter int BASE_ADDR   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [WIDTH-1:0]             fifo_data,
   input  logic                         fifo_empty,
   output logic                         fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]        avm_address,
   output logic                         avm_write,
   output logic [WIDTH-1:0]             avm_writedata,
   output logic [$clog2(BURST_LEN):0]   avm_burstcount,
   input  logic                         avm_waitrequest,
   output logic                         busy,
   output logic                         frame_done,
   output logic [15:0]                  frame_count
);

   localparam int BW = $clog2(BURST_LEN);
   localparam int CW = BW + 1;
   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] END_A  = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS);

   typedef enum logic [1:0] {IDLE, FILL, BURST} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         pops_issued, cap_idx;
   logic [BW-1:0]         beat;
   logic                  pop_pend;
   logic                  pop_acc, beat_acc, last_beat;
   logic [ADDR_WIDTH-1:0] addr_adv;
   logic [WIDTH-1:0]      data_buf [BURST_LEN];

   assign fifo_rd_en     = (state == FILL) & ~fifo_empty & (pops_issued < CW'(BURST_LEN));
   assign pop_acc        = fifo_rd_en & ~fifo_empty;
   assign avm_write      = (state == BURST);
   assign avm_writedata  = data_buf[beat];
   assign avm_burstcount = CW'(BURST_LEN);
   assign beat_acc       = avm_write & ~avm_waitrequest;
   assign last_beat      = beat_acc & (beat == BW'(BURST_LEN - 1));
   assign busy           = (state != IDLE);
   assign addr_adv       = avm_address + ADDR_WIDTH'(BURST_LEN);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = FILL;
         FILL:    if (cap_idx == CW'(BURST_LEN)) state_nxt = BURST;
         BURST:   if (last_beat) state_nxt = enable ? FILL : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         avm_address <= BASE_A;
         pops_issued <= '0;
         cap_idx     <= '0;
         beat        <= '0;
         pop_pend    <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         state      <= state_nxt;
         frame_done <= 1'b0;
         // FIFO data lands one cycle after the accepted pop
         pop_pend   <= pop_acc;
         if (pop_acc)  pops_issued <= pops_issued + CW'(1);
         if (pop_pend) cap_idx     <= cap_idx + CW'(1);
         if (beat_acc) beat        <= beat + BW'(1);
         if (last_beat) begin
            pops_issued <= '0;
            cap_idx     <= '0;
            beat        <= '0;
            if (addr_adv == END_A) begin
               avm_address <= BASE_A;
               frame_done  <= 1'b1;
               frame_count <= frame_count + 16'd1;
            end else begin
               avm_address <= addr_adv;
            end
         end
      end
   end

   // Staging buffer carries no reset; its contents are meaningless until filled.
   always_ff @(posedge clk) begin
      if (pop_pend) data_buf[cap_idx[BW-1:0]] <= fifo_data;
   end

endmodule
